// File: rtl/sram_axil_pkg.sv
// Shared types and helpers for the AXI4-Lite SRAM slave.
// Holds response codes, FSM state encoding and width helpers.
package sram_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RRESP = 2'd1,
        S_BRESP = 2'd2
    } state_t;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_bits(
        input int mem_bytes,
        input int data_w
    );
        return $clog2(mem_bytes / (data_w / 8));
    endfunction

endpackage

// File: rtl/sram_axil_if.sv
// AXI4-Lite style bundle: AR, R, AW, W and B channels.
// master drives requests / response readys, slave the rest.
interface sram_axil_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic [ADDR_W-1:0] readAddr_addr;
    logic              readAddr_valid;
    logic              readAddr_ready;

    logic [DATA_W-1:0] readData_data;
    logic [1:0]        readData_resp;
    logic              readData_valid;
    logic              readData_ready;

    logic [ADDR_W-1:0] writeAddr_addr;
    logic              writeAddr_valid;
    logic              writeAddr_ready;

    logic [DATA_W-1:0] writeData_data;
    logic [BYTES-1:0]  writeData_strb;
    logic              writeData_valid;
    logic              writeData_ready;

    logic [31:0]       writeResp_msg;
    logic              writeResp_valid;
    logic              writeResp_ready;

    modport master (
        output readAddr_addr, readAddr_valid,
        input  readAddr_ready,
        input  readData_data, readData_resp,
        input  readData_valid,
        output readData_ready,
        output writeAddr_addr, writeAddr_valid,
        input  writeAddr_ready,
        output writeData_data, writeData_strb,
        output writeData_valid,
        input  writeData_ready,
        input  writeResp_msg, writeResp_valid,
        output writeResp_ready
    );

    modport slave (
        input  readAddr_addr, readAddr_valid,
        output readAddr_ready,
        output readData_data, readData_resp,
        output readData_valid,
        input  readData_ready,
        input  writeAddr_addr, writeAddr_valid,
        output writeAddr_ready,
        input  writeData_data, writeData_strb,
        input  writeData_valid,
        output writeData_ready,
        output writeResp_msg, writeResp_valid,
        input  writeResp_ready
    );

endinterface

// File: rtl/sram_axil_slave_bank.sv
// Single-port DEPTH x DATA_W array, registered read, byte writes.
// Ports: clk, rst_n, rd_en_i, wr_en_i, be_i, idx_i, wdata_i, rdata_o.
module sram_bank #(
    parameter  int DATA_W = 128,
    parameter  int DEPTH  = 4096,
    localparam int BYTES  = DATA_W / 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic              wr_en_i,
    input  logic [BYTES-1:0]  be_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read register only updates on a read grant, so the
    // response payload stays stable while it is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_axil_slave.sv
// AXI4-Lite SRAM slave: AR/AW/W one-entry buffers, RR arbiter, FSM.
// Ports: clk, rst_n, bus (sram_axil_if.slave). Option: SRAM_AXIL_BOUNDS_CHECK_EN.
module sram_axil_slave
    import sram_axil_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 65536
) (
    input logic        clk,
    input logic        rst_n,
    sram_axil_if.slave bus
);

    localparam int BYTES = bytes_of(DATA_W);
    localparam int OFF_W = off_bits(DATA_W);
    localparam int IDX_W = idx_bits(MEM_BYTES, DATA_W);
    localparam int DEPTH = MEM_BYTES / BYTES;
    localparam int MEM_W = $clog2(MEM_BYTES);

    logic              ar_full_q;
    logic [IDX_W-1:0]  ar_idx_q;
    logic              ar_oob_q;
    logic              aw_full_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic              aw_oob_q;
    logic              w_full_q;
    logic [DATA_W-1:0] w_data_q;
    logic [BYTES-1:0]  w_strb_q;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic [1:0]        rresp_q;
    logic              rerr_q;
    logic [1:0]        bresp_q;

    logic              rd_req, wr_req;
    logic              gnt_rd, gnt_wr;
    logic              ar_hs, aw_hs, w_hs;
    logic              ar_oob_in, aw_oob_in;
    logic [IDX_W-1:0]  bank_idx;
    logic [DATA_W-1:0] bank_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.readAddr_addr,
                                bus.writeAddr_addr};

`ifdef SRAM_AXIL_BOUNDS_CHECK_EN
    // Any address bit at or above MEM_W set means out of range.
    assign ar_oob_in = (bus.readAddr_addr >> MEM_W) != '0;
    assign aw_oob_in = (bus.writeAddr_addr >> MEM_W) != '0;
`else
    assign ar_oob_in = 1'b0;
    assign aw_oob_in = 1'b0;
`endif

    assign ar_hs = bus.readAddr_valid && !ar_full_q;
    assign aw_hs = bus.writeAddr_valid && !aw_full_q;
    assign w_hs  = bus.writeData_valid && !w_full_q;

    // Request buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_full_q <= 1'b0;
            ar_idx_q  <= '0;
            ar_oob_q  <= 1'b0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            aw_oob_q  <= 1'b0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (ar_hs) begin
                ar_full_q <= 1'b1;
                ar_idx_q  <= bus.readAddr_addr[OFF_W +: IDX_W];
                ar_oob_q  <= ar_oob_in;
            end else if (gnt_rd) begin
                ar_full_q <= 1'b0;
            end
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= bus.writeAddr_addr[OFF_W +: IDX_W];
                aw_oob_q  <= aw_oob_in;
            end else if (gnt_wr) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= bus.writeData_data;
                w_strb_q <= bus.writeData_strb;
            end else if (gnt_wr) begin
                w_full_q <= 1'b0;
            end
        end
    end

    // Core state, arbiter priority and response codes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            rresp_q <= RESP_OKAY;
            rerr_q  <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (gnt_rd) begin
                rerr_q  <= ar_oob_q;
                rresp_q <= ar_oob_q ? RESP_SLVERR : RESP_OKAY;
            end
            if (gnt_wr) begin
                bresp_q <= aw_oob_q ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt_rd  = 1'b0;
        gnt_wr  = 1'b0;
        rd_req  = ar_full_q;
        wr_req  = aw_full_q && w_full_q;
        unique case (state_q)
            S_IDLE: begin
                // prio only moves when both sides contend.
                if (rd_req && wr_req) begin
                    gnt_rd = !prio_q;
                    gnt_wr = prio_q;
                    prio_d = !prio_q;
                end else begin
                    gnt_rd = rd_req;
                    gnt_wr = wr_req;
                end
                if (gnt_rd) begin
                    state_d = S_RRESP;
                end else if (gnt_wr) begin
                    state_d = S_BRESP;
                end
            end
            S_RRESP: begin
                if (bus.readData_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_BRESP: begin
                if (bus.writeResp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bank_idx = gnt_rd ? ar_idx_q : aw_idx_q;

    sram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en_i (gnt_rd),
        .wr_en_i (gnt_wr && !aw_oob_q),
        .be_i    (w_strb_q),
        .idx_i   (bank_idx),
        .wdata_i (w_data_q),
        .rdata_o (bank_rdata)
    );

    assign bus.readAddr_ready  = !ar_full_q;
    assign bus.writeAddr_ready = !aw_full_q;
    assign bus.writeData_ready = !w_full_q;
    assign bus.readData_valid  = (state_q == S_RRESP);
    assign bus.writeResp_valid = (state_q == S_BRESP);
    assign bus.readData_data   = rerr_q ? '0 : bank_rdata;
    assign bus.readData_resp   = rresp_q;
    assign bus.writeResp_msg   = {30'b0, bresp_q};

endmodule

// File: tb/tb_sram_axil_slave.sv
// Self-checking bench for sram_axil_slave: directed cases plus
// randomized traffic against a word/byte-level memory model.
module tb_sram_axil_slave;

    localparam int DATA_W    = 128;
    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 65536;
    localparam int BYTES     = 16;
    localparam int DEPTH     = MEM_BYTES / BYTES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_axil_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sram_axil_slave #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int r_pol = 1;
    int b_pol = 1;

    logic [127:0] mdata  [DEPTH];
    logic [15:0]  mknown [DEPTH];
    logic [31:0]  arq [$];
    logic [31:0]  awq [$];
    logic [127:0] wdq [$];
    logic [15:0]  wsq [$];
    string        order = "";

    logic         r_pend = 1'b0;
    logic         b_pend = 1'b0;
    logic [127:0] r_last;
    logic [1:0]   r_last_resp;
    logic [31:0]  b_last;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        bus.readData_ready = (r_pol == 2) ?
            1'($urandom_range(0, 1)) : (r_pol == 1);
        bus.writeResp_ready = (b_pol == 2) ?
            1'($urandom_range(0, 1)) : (b_pol == 1);
    end

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit oob(input logic [31:0] a);
`ifdef SRAM_AXIL_BOUNDS_CHECK_EN
        return a >= MEM_BYTES;
`else
        return (a & 32'h0) != 0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a >> 4) % DEPTH;
    endfunction

    // Expected read: data, bit mask of defined bits, response.
    task automatic exp_read(input logic [31:0] a,
                            output logic [127:0] d,
                            output logic [127:0] m,
                            output logic [1:0] r);
        int ix;
        ix = widx(a);
        if (oob(a)) begin
            d = '0;
            m = '1;
            r = 2'b10;
        end else begin
            d = mdata[ix];
            m = '0;
            for (int b = 0; b < BYTES; b++)
                if (mknown[ix][b]) m[8*b +: 8] = 8'hFF;
            r = 2'b00;
        end
    endtask

    task automatic apply_write(input logic [31:0] a,
                               input logic [127:0] d,
                               input logic [15:0] s,
                               output logic [1:0] r);
        int ix;
        ix = widx(a);
        if (oob(a)) begin
            r = 2'b10;
        end else begin
            r = 2'b00;
            for (int b = 0; b < BYTES; b++) begin
                if (s[b]) begin
                    mdata[ix][8*b +: 8] = d[8*b +: 8];
                    mknown[ix][b] = 1'b1;
                end
            end
        end
    endtask

    // Compare process: every response checked on first appearance,
    // then for stability while stalled.
    always @(negedge clk) begin
        logic [31:0]  a;
        logic [127:0] ed, em, wd;
        logic [15:0]  ws;
        logic [1:0]   er;
        if (!rst_n) begin
            arq.delete();
            awq.delete();
            wdq.delete();
            wsq.delete();
            r_pend = 1'b0;
            b_pend = 1'b0;
        end else begin
            if (bus.readData_valid || bus.writeResp_valid)
                chk("one_resp", bus.readData_valid &&
                    bus.writeResp_valid, 0);
            if (bus.readData_valid) begin
                if (!r_pend) begin
                    if (arq.size() == 0) begin
                        chk("r_unexpected", 1, 0);
                    end else begin
                        a = arq.pop_front();
                        exp_read(a, ed, em, er);
                        chk("rdata", bus.readData_data & em, ed & em);
                        chk("rresp", bus.readData_resp, er);
                    end
                    order = {order, "R"};
                    r_pend = 1'b1;
                    r_last = bus.readData_data;
                    r_last_resp = bus.readData_resp;
                end else begin
                    chk("rdata_hold", bus.readData_data, r_last);
                    chk("rresp_hold", bus.readData_resp, r_last_resp);
                end
                if (bus.readData_ready) r_pend = 1'b0;
            end
            if (bus.writeResp_valid) begin
                if (!b_pend) begin
                    if (awq.size() == 0 || wdq.size() == 0) begin
                        chk("b_unexpected", 1, 0);
                    end else begin
                        a = awq.pop_front();
                        wd = wdq.pop_front();
                        ws = wsq.pop_front();
                        apply_write(a, wd, ws, er);
                        chk("bmsg", bus.writeResp_msg, {30'b0, er});
                    end
                    order = {order, "W"};
                    b_pend = 1'b1;
                    b_last = bus.writeResp_msg;
                end else begin
                    chk("bmsg_hold", bus.writeResp_msg, b_last);
                end
                if (bus.writeResp_ready) b_pend = 1'b0;
            end
            if (bus.readAddr_valid && bus.readAddr_ready)
                arq.push_back(bus.readAddr_addr);
            if (bus.writeAddr_valid && bus.writeAddr_ready)
                awq.push_back(bus.writeAddr_addr);
            if (bus.writeData_valid && bus.writeData_ready) begin
                wdq.push_back(bus.writeData_data);
                wsq.push_back(bus.writeData_strb);
            end
        end
    end

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_ar(input logic [31:0] a, output int hs);
        int n;
        n = 0;
        bus.readAddr_addr = a;
        bus.readAddr_valid = 1'b1;
        @(negedge clk);
        while (!bus.readAddr_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.readAddr_ready) chk("ar_timeout", 1, 0);
        hs = cyc + 1;
        @(posedge clk);
        #1;
        bus.readAddr_valid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a, output int hs);
        int n;
        n = 0;
        bus.writeAddr_addr = a;
        bus.writeAddr_valid = 1'b1;
        @(negedge clk);
        while (!bus.writeAddr_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.writeAddr_ready) chk("aw_timeout", 1, 0);
        hs = cyc + 1;
        @(posedge clk);
        #1;
        bus.writeAddr_valid = 1'b0;
    endtask

    task automatic send_w(input logic [127:0] d,
                          input logic [15:0] s,
                          output int hs);
        int n;
        n = 0;
        bus.writeData_data = d;
        bus.writeData_strb = s;
        bus.writeData_valid = 1'b1;
        @(negedge clk);
        while (!bus.writeData_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.writeData_ready) chk("w_timeout", 1, 0);
        hs = cyc + 1;
        @(posedge clk);
        #1;
        bus.writeData_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a,
                           output logic [127:0] d,
                           output logic [1:0] r,
                           output int lat);
        int hs, n;
        n = 0;
        send_ar(a, hs);
        while (!bus.readData_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.readData_valid) chk("r_timeout", 1, 0);
        lat = cyc - hs;
        d = bus.readData_data;
        r = bus.readData_resp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a,
                            input logic [127:0] d,
                            input logic [15:0] s,
                            input int awd, input int wd,
                            output logic [31:0] msg,
                            output int lat);
        int h1, h2, n;
        n = 0;
        fork
            begin step(awd); send_aw(a, h1); end
            begin step(wd); send_w(d, s, h2); end
        join
        while (!bus.writeResp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.writeResp_valid) chk("b_timeout", 1, 0);
        lat = cyc - ((h1 > h2) ? h1 : h2);
        msg = bus.writeResp_msg;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = (32'($urandom_range(0, 15)) << 4) |
            32'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) a = a + 32'h10000;
        return a;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        logic [1:0]   r;
        logic [31:0]  msg;
        int           lat, hs, n;
        logic [127:0] p1, p2, p3, z;

        for (int i = 0; i < DEPTH; i++) begin
            mdata[i] = '0;
            mknown[i] = '0;
        end
        bus.readAddr_addr = '0;
        bus.readAddr_valid = 1'b0;
        bus.writeAddr_addr = '0;
        bus.writeAddr_valid = 1'b0;
        bus.writeData_data = '0;
        bus.writeData_strb = '0;
        bus.writeData_valid = 1'b0;
        bus.readData_ready = 1'b1;
        bus.writeResp_ready = 1'b1;

        p1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        p2 = 128'hDEADBEEF_00000000_CAFEF00D_11112222;
        p3 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        z  = 128'h5A5A5A5A_00000001_00000002_00000003;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", bus.readAddr_ready, 1);
        chk("rst_awready", bus.writeAddr_ready, 1);
        chk("rst_wready", bus.writeData_ready, 1);
        chk("rst_rvalid", bus.readData_valid, 0);
        chk("rst_bvalid", bus.writeResp_valid, 0);
        chk("rst_rdata", bus.readData_data, 0);
        chk("rst_rresp", bus.readData_resp, 0);
        chk("rst_bmsg", bus.writeResp_msg, 0);
        rst_n = 1'b1;
        step(1);

        // Full-word write then read, latency from each handshake.
        do_write(32'h40, p1, 16'hFFFF, 0, 0, msg, lat);
        chk("wr_lat_edges", lat + 1, 2);
        chk("wr_msg", msg, 0);
        do_read(32'h40, d, r, lat);
        chk("rd_lat_edges", lat + 1, 2);
        chk("rd_full", d, p1);
        chk("rd_resp", r, 0);

        // Partial strobe over a 0x55 word.
        do_write(32'h50, {16{8'h55}}, 16'hFFFF, 0, 0, msg, lat);
        do_write(32'h50, {16{8'hAA}}, 16'h000F, 0, 0, msg, lat);
        do_read(32'h5C, d, r, lat);
        chk("rd_strb", d, {{12{8'h55}}, {4{8'hAA}}});

        // AW before W, then W before AW.
        do_write(32'h60, p2, 16'hFFFF, 3, 7, msg, lat);
        chk("aw_first_lat", lat, 1);
        do_write(32'h70, p3, 16'hFFFF, 6, 2, msg, lat);
        chk("w_first_lat", lat, 1);
        do_read(32'h60, d, r, lat);
        chk("rd_aw_first", d, p2);
        do_read(32'h70, d, r, lat);
        chk("rd_w_first", d, p3);

        // Past the end of the array.
        do_write(32'h0, z, 16'hFFFF, 0, 0, msg, lat);
        do_read(32'h10000, d, r, lat);
`ifdef SRAM_AXIL_BOUNDS_CHECK_EN
        chk("oob_rdata", d, 0);
        chk("oob_rresp", r, 2'b10);
        do_write(32'h10000, p1, 16'hFFFF, 0, 0, msg, lat);
        chk("oob_bmsg", msg, 32'h2);
        do_read(32'h0, d, r, lat);
        chk("oob_no_write", d, z);
`else
        chk("wrap_rdata", d, z);
        chk("wrap_rresp", r, 0);
`endif

        // Arbitration: fresh reset pins prio to read first.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        r_pol = 0;
        b_pol = 0;
        step(2);
        order = "";
        send_ar(32'h40, hs);
        step(2);
        fork
            begin
                send_ar(32'h50, hs);
                send_ar(32'h60, hs);
            end
            begin
                fork
                    send_aw(32'h70, hs);
                    send_w(p2, 16'hFFFF, hs);
                join
                fork
                    send_aw(32'h80, hs);
                    send_w(p3, 16'h00FF, hs);
                join
            end
            begin
                step(4);
                chk("stall_rvalid", bus.readData_valid, 1);
                chk("stall_ar_full", bus.readAddr_ready, 0);
                chk("stall_aw_full", bus.writeAddr_ready, 0);
                chk("stall_w_full", bus.writeData_ready, 0);
                r_pol = 1;
                b_pol = 1;
            end
        join
        n = 0;
        while (order.len() < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (order != "RRWRW") begin
            fails++;
            $display("FAIL grant_order: got %s expected RRWRW",
                     order);
        end
        step(2);

        // Reset during a stalled read with a write buffered.
        do_write(32'h90, p1, 16'hFFFF, 0, 0, msg, lat);
        r_pol = 0;
        step(1);
        send_ar(32'h40, hs);
        step(2);
        fork
            send_aw(32'h90, hs);
            send_w(p2, 16'hFFFF, hs);
        join
        step(1);
        chk("pre_rst_awfull", bus.writeAddr_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", bus.readData_valid, 0);
        chk("arst_bvalid", bus.writeResp_valid, 0);
        chk("arst_arready", bus.readAddr_ready, 1);
        chk("arst_awready", bus.writeAddr_ready, 1);
        chk("arst_wready", bus.writeData_ready, 1);
        r_pol = 1;
        step(2);
        rst_n = 1'b1;
        step(2);
        do_read(32'h90, d, r, lat);
        chk("rst_drop_write", d, p1);

        // Randomized traffic.
        r_pol = 2;
        b_pol = 2;
        fork
            repeat (150) begin
                int h;
                step($urandom_range(0, 2));
                send_ar(rand_addr(), h);
            end
            repeat (150) begin
                int h;
                step($urandom_range(0, 3));
                send_aw(rand_addr(), h);
            end
            repeat (150) begin
                int h;
                step($urandom_range(0, 3));
                send_w({$urandom, $urandom, $urandom, $urandom},
                       16'($urandom), h);
            end
        join
        n = 0;
        while ((arq.size() != 0 || awq.size() != 0 ||
                bus.readData_valid || bus.writeResp_valid) &&
               n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_ar", arq.size(), 0);
        chk("drain_aw", awq.size(), 0);
        chk("drain_w", wdq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_axil_slave.md
# sram_axil_slave

Parametrised AXI4-Lite slave SRAM: the next-generation on-chip data memory. It generalises the fixed 128-bit / 64 KiB memory to configurable data width and depth. Read and write channels are fully independent, with a round-robin arbiter onto one single-port array, per-byte strobes and a two-bit response code on both response channels. It sits on the system interconnect as the main scratch/data memory behind the cache and DMA masters.

## Interface
- DATA_W, 128: data bus width in bits; power of two, 32..512; BYTES = DATA_W/8.
- ADDR_W, 32: AXI address width.
- MEM_BYTES, 65536: storage size in bytes; power of two, multiple of BYTES; DEPTH = MEM_BYTES/BYTES words.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- readAddr_addr  in  ADDR_W  read byte address; low log2(BYTES) bits ignored (word aligned).
- readAddr_valid  in  1 / readAddr_ready  out  1.
- readData_data  out  DATA_W  read word.
- readData_resp  out  2  00 OKAY, 10 SLVERR.
- readData_valid  out  1 / readData_ready  in  1.
- writeAddr_addr  in  ADDR_W  write byte address, aligned as for reads.
- writeAddr_valid  in  1 / writeAddr_ready  out  1.
- writeData_data  in  DATA_W / writeData_strb  in  BYTES  byte enables, bit i covers data[8i+7:8i].
- writeData_valid  in  1 / writeData_ready  out  1.
- writeResp_msg  out  32  [1:0] response code, [31:2] zero.
- writeResp_valid  out  1 / writeResp_ready  in  1.

## Operation
- Handshake on any channel: transfer when valid && ready at a rising edge. valid, once raised by this block, is held with stable payload until ready.
- Input buffers, one entry each: AR (address), AW (address), W (data + strb). readAddr_ready = AR empty; writeAddr_ready = AW empty; writeData_ready = W empty. AW and W are accepted in either order or in the same cycle; the strobe is captured with the data.
- Core FSM: IDLE, RRESP, BRESP.
  - IDLE: rd_req = AR full; wr_req = AW full && W full. Only rd_req: read the array into readData_data, free AR, go to RRESP. Only wr_req: write the strobed bytes, free AW and W, go to BRESP. Both: grant by priority bit prio (0 = read), then toggle prio. Neither: stay.
  - RRESP: readData_valid = 1; on readData_ready go to IDLE.
  - BRESP: writeResp_valid = 1; on writeResp_ready go to IDLE.
- A buffer freed on a grant edge may accept a new request in the next cycle, while the response is still pending.
- Word index = (addr >> log2(BYTES)) mod DEPTH. Array contents are not reset.
- Reset mid-transaction drops all buffered requests and responses. A write granted before reset assertion has completed; a write not yet granted is lost.

## Timing
- Reset values: readAddr_ready = writeAddr_ready = writeData_ready = 1; readData_valid = writeResp_valid = 0; readData_data = 0; readData_resp = 00; writeResp_msg = 0; prio = 0; FSM = IDLE.
- Read: AR handshake at edge n → readData_valid high in cycle n+1 (array read on edge n+1, minimum latency 2 edges).
- Write: last of AW/W handshake at edge n → array written at edge n+1 → writeResp_valid in cycle n+1.
- Responses are held until their ready; there is no timeout.
- Throughput: one access per 2 cycles with ready tied high.

## Configuration
- SRAM_AXIL_BOUNDS_CHECK_EN defined: a byte address ≥ MEM_BYTES is an error. A read returns data 0 with resp 10. A write leaves the array unchanged and responds 10. Both still take the normal FSM path and latency.
- Undefined: no check, the address wraps modulo MEM_BYTES, and resp is always 00.

## Structure
- Package sram_axil_pkg: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, FSM state typedef, clog2-based BYTES/index-width helpers.
- Sub-module sram_bank: DEPTH × DATA_W single-port array with a registered read port and a per-byte write enable. The arbiter, buffers and FSM stay in the top level.

## Test plan
- Write 0x0123..EF (128 bit) to 0x40 with strb=0xFFFF, then read 0x40 → identical data, resp 00, latency 2 edges from each handshake.
- Write strb=0x000F data 0xAA.. over a word holding 0x55.., read back → bytes 0–3 = 0xAA, bytes 4–15 = 0x55.
- Send AW at cycle 3 and W at cycle 7 (W-before-AW also) → single write, writeResp_valid asserted the cycle after the later handshake.
- Keep read and write requests pending back-to-back for 4 grants → grant order read, write, read, write; both buffers re-accept while the response is stalled by ready=0.
- Read 0x10000 with MEM_BYTES=65536 → with macro: data 0, resp 10, and a write there changes nothing; without macro: returns word 0.
- Drop rst_n while in RRESP with AW buffered → all valids 0 and all readys 1 asynchronously; the buffered write is never performed.
